// File: rtl/awm_plant_model.sv
// rtl/awm_plant_model.sv - washing machine plant/sensor emulator for closed-loop sim and FPGA demo
// Optional leak model enabled by defining AWM_PLANT_LEAK_EN.
module awm_plant_model #(
  parameter int TICK_DIV    = 4,
  parameter int LVL_W       = 6,
  parameter int FULL_LEVEL  = 40,
  parameter int DET_TICKS   = 3,
  parameter int CYCLE_TICKS = 20,
  parameter int SPIN_TICKS  = 10
`ifdef AWM_PLANT_LEAK_EN
  , parameter int LEAK_PERIOD = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             door_toggle,
  input  logic             doorlock,
  input  logic             motoron,
  input  logic             fillvalve,
  input  logic             drainvalve,
  output logic             doorclose,
  output logic             filled,
  output logic             drained,
  output logic             detergent,
  output logic             cycletout,
  output logic             spintout,
  output logic             fault,
  output logic [LVL_W-1:0] level
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DET_TICKS + 1);
  localparam int CW = $clog2(CYCLE_TICKS + 1);
  localparam int SW = $clog2(SPIN_TICKS + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};
  localparam logic [LVL_W-1:0] FULL_L  = LVL_W'(FULL_LEVEL);

  logic [PW-1:0]    presc;
  logic             tick;
  logic             leak;
  logic [LVL_W-1:0] lvl_nxt;
  logic [DW-1:0]    det_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic [SW-1:0]    spin_cnt;
  logic             spin_cond;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign spin_cond = drainvalve && drained;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + 1'b1;
  end

`ifdef AWM_PLANT_LEAK_EN
  localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  logic [LW-1:0] leak_cnt;

  // Leak interval restarts whenever the fill valve opens.
  assign leak = tick && !fillvalve && (leak_cnt == LW'(LEAK_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          leak_cnt <= '0;
    else if (fillvalve)  leak_cnt <= '0;
    else if (tick)       leak_cnt <= leak ? '0 : leak_cnt + 1'b1;
  end
`else
  assign leak = 1'b0;
`endif

  // Leak and drain on the same tick still remove only one unit.
  always_comb begin
    lvl_nxt = level;
    if (tick) begin
      if (fillvalve && !drainvalve) begin
        if (level != LVL_MAX) lvl_nxt = level + 1'b1;
      end else if ((drainvalve && !fillvalve) || leak) begin
        if (level != '0) lvl_nxt = level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      filled  <= 1'b0;
      drained <= 1'b1;
      fault   <= 1'b0;
    end else begin
      level   <= lvl_nxt;
      filled  <= (lvl_nxt >= FULL_L);
      drained <= (lvl_nxt == '0);
      if (tick && fillvalve && drainvalve) fault <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       doorclose <= 1'b0;
    else if (door_toggle && !doorlock) doorclose <= ~doorclose;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_cnt   <= '0;
      detergent <= 1'b0;
    end else if (!doorlock) begin
      det_cnt   <= '0;
      detergent <= 1'b0;
    end else if (tick && filled && !motoron && !fillvalve && !drainvalve &&
                 det_cnt != DW'(DET_TICKS)) begin
      det_cnt <= det_cnt + 1'b1;
      if (det_cnt == DW'(DET_TICKS - 1)) detergent <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      cycletout <= 1'b0;
    end else if (!motoron) begin
      cyc_cnt   <= '0;
      cycletout <= 1'b0;
    end else if (tick && cyc_cnt != CW'(CYCLE_TICKS)) begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (cyc_cnt == CW'(CYCLE_TICKS - 1)) cycletout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spin_cnt <= '0;
      spintout <= 1'b0;
    end else if (!spin_cond) begin
      spin_cnt <= '0;
      spintout <= 1'b0;
    end else if (tick && spin_cnt != SW'(SPIN_TICKS)) begin
      spin_cnt <= spin_cnt + 1'b1;
      if (spin_cnt == SW'(SPIN_TICKS - 1)) spintout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_awm_plant_model.sv
// tb/tb_awm_plant_model.sv - directed self-checking bench for awm_plant_model
module tb_awm_plant_model;

  logic       clk = 1'b0;
  logic       rst_n, door_toggle, doorlock, motoron, fillvalve, drainvalve;
  logic       doorclose, filled, drained, detergent, cycletout, spintout, fault;
  logic [5:0] level;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  awm_plant_model dut (
    .clk(clk), .rst_n(rst_n), .door_toggle(door_toggle), .doorlock(doorlock),
    .motoron(motoron), .fillvalve(fillvalve), .drainvalve(drainvalve),
    .doorclose(doorclose), .filled(filled), .drained(drained),
    .detergent(detergent), .cycletout(cycletout), .spintout(spintout),
    .fault(fault), .level(level)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n * 4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_door();
    door_toggle = 1'b1;
    @(posedge clk); #1;
    door_toggle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, fell;
    rst_n = 1'b0; door_toggle = 1'b0; doorlock = 1'b0;
    motoron = 1'b0; fillvalve = 1'b0; drainvalve = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_drained", drained, 1);
    chk("rst_filled", filled, 0);
    chk("rst_doorclose", doorclose, 0);
    chk("rst_detergent", detergent, 0);
    chk("rst_cycletout", cycletout, 0);
    chk("rst_spintout", spintout, 0);
    chk("rst_fault", fault, 0);

    rst_n = 1'b1;
    door_toggle = 1'b1;
    @(posedge clk); #1;
    door_toggle = 1'b0;
    chk("door_open_close", doorclose, 1);

    fillvalve = 1'b1;
    n = 0;
    while (level != 6'd17 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fill_to_17", level, 17);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_level", level, 0);
    chk("midrst_drained", drained, 1);
    chk("midrst_door", doorclose, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0; fell = 0;
    while (!filled && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (!drained && fell == 0) fell = n;
    end
    chk("fill_clk_to_filled", n, 160);
    chk("fill_drained_fall", fell, 4);
    chk("fill_level", level, 40);
    fillvalve = 1'b0;

    pulse_door();
    chk("door_toggle_unlocked", doorclose, 1);
    doorlock = 1'b1;
    pulse_door();
    pulse_door();
    chk("door_locked_ignored", doorclose, 1);
    doorlock = 1'b0;
    pulse_door();
    chk("door_toggle_1to0", doorclose, 0);

    doorlock = 1'b1;
    ticks(2);
    chk("det_before", detergent, 0);
    ticks(1);
    chk("det_after3", detergent, 1);

    motoron = 1'b1;
    ticks(19);
    chk("cyc_before", cycletout, 0);
    ticks(1);
    chk("cyc_at20", cycletout, 1);
    ticks(1);
    chk("cyc_held", cycletout, 1);
    chk("det_sticky", detergent, 1);
    motoron = 1'b0;
    @(posedge clk); #1;
    chk("cyc_clear", cycletout, 0);
    repeat (3) @(posedge clk);
    #1;

    drainvalve = 1'b1;
    ticks(1);
    chk("drain_level39", level, 39);
    chk("drain_unfilled", filled, 0);
    ticks(38);
    chk("drain_level1", level, 1);
    chk("drain_not_empty", drained, 0);
    ticks(1);
    chk("drain_level0", level, 0);
    chk("drain_empty", drained, 1);
    ticks(9);
    chk("spin_before", spintout, 0);
    ticks(1);
    chk("spin_at10", spintout, 1);
    chk("drain_sat0", level, 0);

    drainvalve = 1'b0;
    fillvalve  = 1'b1;
    @(posedge clk); #1;
    chk("spin_clear", spintout, 0);
    repeat (3) @(posedge clk);
    #1;
    ticks(4);
    chk("refill_level5", level, 5);
    chk("fault_clean", fault, 0);

    drainvalve = 1'b1;
    ticks(3);
    chk("conflict_level", level, 5);
    chk("conflict_fault", fault, 1);
    fillvalve  = 1'b0;
    drainvalve = 1'b0;
`ifdef AWM_PLANT_LEAK_EN
    ticks(7);
    chk("leak_before", level, 5);
    ticks(1);
    chk("leak_level4", level, 4);
`else
    ticks(8);
    chk("idle_no_leak", level, 5);
`endif
    chk("fault_sticky", fault, 1);

    rst_n = 1'b0;
    #1;
    chk("final_rst_fault", fault, 0);
    chk("final_rst_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/awm_plant_model.md
Name: awm_plant_model

Overview:
- Behavioural plant/sensor emulator for the automatic washing machine controller. It is the other end of the controller's actuator/sensor interface.
- Consumes the actuator commands (doorlock, motoron, fillvalve, drainvalve) and produces the sensor and timeout inputs (doorclose, filled, detergent, cycletout, drained, spintout).
- Synthesisable. Used for closed-loop simulation and FPGA demo in place of the real appliance.

Parameters:
- TICK_DIV, 4, clk cycles per plant tick (>=1); all level and timer activity advances only on a tick.
- LVL_W, 6, width of water-level counter.
- FULL_LEVEL, 40, level at or above which filled=1 (must be < 2^LVL_W).
- DET_TICKS, 3, ticks of dispenser activity before detergent=1.
- CYCLE_TICKS, 20, motor-on ticks before cycletout=1.
- SPIN_TICKS, 10, spin ticks before spintout=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- door_toggle  in  1  user door push-button, single-cycle pulse
- doorlock  in  1  controller lock command
- motoron  in  1  controller drum motor command
- fillvalve  in  1  controller fill valve command
- drainvalve  in  1  controller drain valve command
- doorclose  out  1  door-closed sensor
- filled  out  1  water level >= FULL_LEVEL
- drained  out  1  water level == 0
- detergent  out  1  dispenser-complete sensor
- cycletout  out  1  wash-cycle timer expired
- spintout  out  1  spin timer expired
- fault  out  1  sticky illegal-command flag
- level  out  LVL_W  current water level, debug

Behaviour:
- Clock, reset and tick:
  - Single clock clk. Reset rst_n is asynchronous and active-low.
  - While rst_n=0, all registers clear: doorclose=0, level=0, drained=1, filled=0, detergent=0, cycletout=0, spintout=0, fault=0, prescaler=0.
  - Prescaler counts 0..TICK_DIV-1. tick=1 for one clk when the count equals TICK_DIV-1, then it wraps to 0.
- Door:
  - door_toggle=1 with doorlock=0 inverts doorclose on the next clk edge.
  - door_toggle is ignored while doorlock=1.
  - door_toggle is not tick-gated.
- Water level (on tick only):
  - fillvalve=1, drainvalve=0: level+1, saturating at 2^LVL_W-1.
  - drainvalve=1, fillvalve=0: level-1, saturating at 0.
  - Both=1: level unchanged and fault set; fault stays 1 until reset.
  - Both=0: level unchanged.
- filled and drained are registered, derived from the next level value. They update in the same edge as level and have 1-clk latency from tick.
- Detergent dispenser:
  - Counter advances on tick while doorlock=1, filled=1, and motoron, fillvalve, drainvalve are all 0.
  - After DET_TICKS ticks, detergent=1.
  - detergent is sticky until doorlock=0, which clears the counter and detergent.
- Cycle timer:
  - Counts ticks while motoron=1. At CYCLE_TICKS, cycletout=1 and is held.
  - motoron=0 clears the counter and cycletout on the next clk.
- Spin timer:
  - Counts ticks while drainvalve=1 and drained=1 (drum spinning empty). At SPIN_TICKS, spintout=1 and is held.
  - When the condition drops, the counter and spintout clear on the next clk.
- Timer counters saturate at their terminal value and do not wrap.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously).
- fault does not block any other behaviour.

Optional Feature:
- Macro: AWM_PLANT_LEAK_EN.
- When defined: adds parameter LEAK_PERIOD (default 8). Every LEAK_PERIOD ticks with fillvalve=0, level decrements by 1 (saturating at 0). This models a leak for controller robustness tests.
- If a leak tick coincides with a drain tick, the decrement is 1, not 2.
- When undefined: no leak logic; level changes only via the valves.

Test Plan:
- Reset: rst_n=0 mid-fill at level=17 -> level=0, drained=1, all other outputs 0 within the same cycle.
- Fill: TICK_DIV=4, fillvalve=1 from level 0 -> filled rises exactly 40 ticks (160 clk) later; drained falls after the first tick.
- Door interlock: doorlock=1 with door_toggle pulses -> doorclose unchanged. doorlock=0 then one pulse -> doorclose toggles 1->0.
- Detergent and cycle: locked, filled, idle for 3 ticks -> detergent=1. Then motoron=1 for 20 ticks -> cycletout=1. motoron=0 -> cycletout=0 next clk.
- Spin and conflict: drain to 0 with drainvalve held -> spintout after 10 further ticks. fillvalve=drainvalve=1 -> level frozen, fault=1 and sticky.
- Leak (macro defined): LEAK_PERIOD=8, level=40, all valves off -> level=39 after 8 ticks and filled drops.
